// File: rtl/z85_intc_pkg.sv
// Shared types and constants for the Z85 interrupt acceptance sequencer.
package z85_intc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTA,
    ST_PUSH_H,
    ST_PUSH_L,
    ST_VEC_L,
    ST_VEC_H,
    ST_LOAD
  } z85_intc_state_e;

  typedef enum logic [1:0] {
    BUS_INTA   = 2'd0,
    BUS_MEM_WR = 2'd1,
    BUS_MEM_RD = 2'd2
  } z85_bus_op_e;

  localparam logic [7:0] RST_MASK       = 8'h38;
  localparam logic [7:0] RST_MATCH_MASK = 8'hC7;
  localparam logic [7:0] RST_MATCH_PAT  = 8'hC7;

  // IM0 only honours RST opcodes; anything else on the bus behaves as RST 38h.
  function automatic logic [15:0] im0_target(input logic [7:0] op);
    if ((op & RST_MATCH_MASK) == RST_MATCH_PAT) return {8'h00, op & RST_MASK};
    return {8'h00, RST_MASK};
  endfunction

  function automatic logic is_bus_state(input z85_intc_state_e s);
    return (s == ST_INTA) || (s == ST_PUSH_H) || (s == ST_PUSH_L) ||
           (s == ST_VEC_L) || (s == ST_VEC_H);
  endfunction

endpackage

// File: rtl/z85_nmi_sync.sv
// NMI synchronizer with falling-edge detector; nmi_edge_o is a one-cycle pulse.
module z85_nmi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n_i,
  output logic nmi_edge_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Chain resets to the inactive (high) level so release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= nmi_n_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign nmi_edge_o = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/z85_int_ctrl.sv
// Z85 interrupt acceptance sequencer: owns IFF1/IFF2/IM/halt and runs INTA, push, vector fetch.
// Optional latency counter and irq_lat_o port under `define Z85_INTC_LATCNT_EN.
module z85_int_ctrl
  import z85_intc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'h0066,
  parameter logic [15:0] IM1_VEC     = 16'h0038
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boundary_i,
  input  logic        ei_i,
  input  logic        di_i,
  input  logic        retn_i,
  input  logic        halt_i,
  input  logic        im_wr_i,
  input  logic [1:0]  im_val_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] sp_i,
  input  logic [7:0]  i_reg_i,
  input  logic        nmi_n_i,
  input  logic        int_n_i,
  output logic        bus_req_o,
  output logic [1:0]  bus_op_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [7:0]  bus_rdata_i,
  output logic        stall_o,
  output logic        pc_wr_o,
  output logic [15:0] pc_wdata_o,
  output logic        sp_wr_o,
  output logic [15:0] sp_wdata_o,
  output logic        iff1_o,
  output logic        iff2_o,
  output logic [1:0]  im_o,
  output logic        halt_o
`ifdef Z85_INTC_LATCNT_EN
  ,
  output logic [15:0] irq_lat_o
`endif
);

  z85_intc_state_e        r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_int_sync;
  logic                   w_int_sync;
  logic                   w_nmi_edge;
  logic                   r_nmi_pend;
  logic                   r_iff1, r_iff2, r_halt, r_im2, r_bus_req;
  logic [1:0]             r_im;
  logic [15:0]            r_pc, r_sp, r_tgt, r_vaddr;
  logic                   w_idle, w_eff_bnd, w_int_ok, w_acc_nmi, w_acc_int, w_accept, w_ack;
  logic [15:0]            w_sp_m1, w_sp_m2;

  z85_nmi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .nmi_n_i    (nmi_n_i),
    .nmi_edge_o (w_nmi_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_sync <= '1;
    end else begin
      r_int_sync[0] <= int_n_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_int_sync[i] <= r_int_sync[i-1];
    end
  end
  assign w_int_sync = r_int_sync[SYNC_STAGES-1];

  assign w_idle    = (r_state == ST_IDLE);
  assign w_eff_bnd = boundary_i | r_halt;
  assign w_int_ok  = ~w_int_sync & r_iff1 & ~ei_i & ~di_i;
  assign w_acc_nmi = w_idle & w_eff_bnd & r_nmi_pend;
  assign w_acc_int = w_idle & w_eff_bnd & ~r_nmi_pend & w_int_ok;
  assign w_accept  = w_acc_nmi | w_acc_int;
  assign w_ack     = r_bus_req & bus_ack_i;
  assign w_sp_m1   = r_sp - 16'd1;
  assign w_sp_m2   = r_sp - 16'd2;

  // Architectural fields: acceptance updates are placed last so they win over instruction effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iff1     <= 1'b0;
      r_iff2     <= 1'b0;
      r_halt     <= 1'b0;
      r_im       <= '0;
      r_nmi_pend <= 1'b0;
    end else begin
      if (w_idle && boundary_i) begin
        if (di_i) begin
          r_iff1 <= 1'b0;
          r_iff2 <= 1'b0;
        end else if (ei_i) begin
          r_iff1 <= 1'b1;
          r_iff2 <= 1'b1;
        end else if (retn_i) begin
          r_iff1 <= r_iff2;
        end
        if (halt_i)  r_halt <= 1'b1;
        if (im_wr_i) r_im   <= im_val_i;
      end
      if (w_acc_nmi) begin
        r_iff2 <= r_iff1;
        r_iff1 <= 1'b0;
      end else if (w_acc_int) begin
        r_iff1 <= 1'b0;
        r_iff2 <= 1'b0;
      end
      if (w_accept) r_halt <= 1'b0;
      if (w_nmi_edge)     r_nmi_pend <= 1'b1;
      else if (w_acc_nmi) r_nmi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_sp    <= '0;
      r_tgt   <= '0;
      r_vaddr <= '0;
      r_im2   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc  <= pc_i;
        r_sp  <= sp_i;
        r_tgt <= w_acc_nmi ? NMI_VEC : '0;
        r_im2 <= w_acc_int & (r_im == 2'd2);
      end
      if (w_ack) begin
        unique case (r_state)
          ST_INTA: begin
            r_vaddr <= {i_reg_i, bus_rdata_i};
            if (r_im == 2'd1)      r_tgt <= IM1_VEC;
            else if (r_im != 2'd2) r_tgt <= im0_target(bus_rdata_i);
          end
          ST_VEC_L: r_tgt[7:0]  <= bus_rdata_i;
          ST_VEC_H: r_tgt[15:8] <= bus_rdata_i;
          default: ;
        endcase
      end
    end
  end

  // Request is held across back-to-back bus states, otherwise rises a cycle after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bus_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_req <= is_bus_state(r_state) & (~w_ack | is_bus_state(w_state_nxt));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc_nmi)      w_state_nxt = ST_PUSH_H;
        else if (w_acc_int) w_state_nxt = ST_INTA;
      end
      ST_INTA:   if (w_ack) w_state_nxt = ST_PUSH_H;
      ST_PUSH_H: if (w_ack) w_state_nxt = ST_PUSH_L;
      ST_PUSH_L: if (w_ack) w_state_nxt = r_im2 ? ST_VEC_L : ST_LOAD;
      ST_VEC_L:  if (w_ack) w_state_nxt = ST_VEC_H;
      ST_VEC_H:  if (w_ack) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_op_o    = BUS_INTA;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    pc_wr_o     = 1'b0;
    pc_wdata_o  = '0;
    sp_wr_o     = 1'b0;
    sp_wdata_o  = '0;
    unique case (r_state)
      ST_INTA: begin
        bus_op_o   = BUS_INTA;
        bus_addr_o = r_pc;
      end
      ST_PUSH_H: begin
        bus_op_o    = BUS_MEM_WR;
        bus_addr_o  = w_sp_m1;
        bus_wdata_o = r_pc[15:8];
      end
      ST_PUSH_L: begin
        bus_op_o    = BUS_MEM_WR;
        bus_addr_o  = w_sp_m2;
        bus_wdata_o = r_pc[7:0];
      end
      ST_VEC_L: begin
        bus_op_o   = BUS_MEM_RD;
        bus_addr_o = r_vaddr;
      end
      ST_VEC_H: begin
        bus_op_o   = BUS_MEM_RD;
        bus_addr_o = r_vaddr + 16'd1;
      end
      ST_LOAD: begin
        pc_wr_o    = 1'b1;
        pc_wdata_o = r_tgt;
        sp_wr_o    = 1'b1;
        sp_wdata_o = w_sp_m2;
      end
      default: ;
    endcase
  end

  assign bus_req_o = r_bus_req;
  assign stall_o   = ~w_idle | w_accept;
  assign iff1_o    = r_iff1;
  assign iff2_o    = r_iff2;
  assign im_o      = r_im;
  assign halt_o    = r_halt;

`ifdef Z85_INTC_LATCNT_EN
  logic [15:0] r_lat_cnt, r_irq_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
      r_irq_lat <= '0;
    end else begin
      if (w_int_sync || w_acc_int)  r_lat_cnt <= '0;
      else if (r_lat_cnt != '1)     r_lat_cnt <= r_lat_cnt + 16'd1;
      if (w_acc_int) r_irq_lat <= r_lat_cnt;
    end
  end

  assign irq_lat_o = r_irq_lat;
`endif

endmodule

// File: tb/tb_z85_int_ctrl.sv
// Directed self-checking bench for z85_int_ctrl with a simple acking bus/memory responder.
module tb_z85_int_ctrl;

  logic        clk, rst_n;
  logic        boundary_i, ei_i, di_i, retn_i, halt_i, im_wr_i;
  logic [1:0]  im_val_i;
  logic [15:0] pc_i, sp_i;
  logic [7:0]  i_reg_i;
  logic        nmi_n_i, int_n_i;
  logic        bus_req_o;
  logic [1:0]  bus_op_o;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_wdata_o;
  logic        bus_ack_i;
  logic [7:0]  bus_rdata_i;
  logic        stall_o, pc_wr_o, sp_wr_o;
  logic [15:0] pc_wdata_o, sp_wdata_o;
  logic        iff1_o, iff2_o, halt_o;
  logic [1:0]  im_o;
`ifdef Z85_INTC_LATCNT_EN
  logic [15:0] irq_lat_o;
`endif

  int total = 0;
  int bad   = 0;

  z85_int_ctrl #(.SYNC_STAGES(2), .NMI_VEC(16'h0066), .IM1_VEC(16'h0038)) dut (
    .clk(clk), .rst_n(rst_n), .boundary_i(boundary_i), .ei_i(ei_i), .di_i(di_i),
    .retn_i(retn_i), .halt_i(halt_i), .im_wr_i(im_wr_i), .im_val_i(im_val_i),
    .pc_i(pc_i), .sp_i(sp_i), .i_reg_i(i_reg_i), .nmi_n_i(nmi_n_i), .int_n_i(int_n_i),
    .bus_req_o(bus_req_o), .bus_op_o(bus_op_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .pc_wr_o(pc_wr_o), .pc_wdata_o(pc_wdata_o), .sp_wr_o(sp_wr_o),
    .sp_wdata_o(sp_wdata_o), .iff1_o(iff1_o), .iff2_o(iff2_o), .im_o(im_o), .halt_o(halt_o)
`ifdef Z85_INTC_LATCNT_EN
    , .irq_lat_o(irq_lat_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responder: acks after ack_wait idle cycles while ack_budget lasts, logs every transfer.
  int unsigned ack_wait   = 0;
  int unsigned ack_budget = 1000;
  int unsigned wcnt       = 0;
  logic [7:0]  inta_byte  = 8'hFF;
  logic [7:0]  mem [bit [15:0]];
  logic [1:0]  log_op   [8];
  logic [15:0] log_addr [8];
  logic [7:0]  log_data [8];
  int          log_n = 0;

  always @(negedge clk) begin
    bus_ack_i = 1'b0;
    if (rst_n && bus_req_o && ack_budget != 0) begin
      if (wcnt >= ack_wait) begin
        bus_ack_i = 1'b1;
        wcnt = 0;
        ack_budget--;
        case (bus_op_o)
          2'd0: bus_rdata_i = inta_byte;
          2'd1: begin mem[bus_addr_o] = bus_wdata_o; bus_rdata_i = 8'h00; end
          default: bus_rdata_i = mem.exists(bus_addr_o) ? mem[bus_addr_o] : 8'hFF;
        endcase
        if (log_n < 8) begin
          log_op[log_n]   = bus_op_o;
          log_addr[log_n] = bus_addr_o;
          log_data[log_n] = bus_wdata_o;
        end
        log_n++;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  int          pcw_cnt = 0;
  logic [15:0] pcw_val = '0, spw_val = '0;
  logic        spw_seen = 1'b0;

  always @(negedge clk) begin
    if (pc_wr_o) begin
      pcw_cnt++;
      pcw_val  = pc_wdata_o;
      spw_val  = sp_wdata_o;
      spw_seen = sp_wr_o;
    end
  end

  task automatic clr_inputs();
    boundary_i = 0; ei_i = 0; di_i = 0; retn_i = 0; halt_i = 0; im_wr_i = 0; im_val_i = 0;
  endtask

  // One-cycle instruction boundary; st returns stall_o seen in that cycle.
  task automatic bnd(input logic ei, input logic di, input logic retn, input logic hlt,
                     input logic imw, input logic [1:0] imv, output logic st);
    @(posedge clk); #1;
    boundary_i = 1; ei_i = ei; di_i = di; retn_i = retn; halt_i = hlt; im_wr_i = imw; im_val_i = imv;
    @(negedge clk);
    st = stall_o;
    @(posedge clk); #1;
    clr_inputs();
  endtask

  task automatic wait_load(input int base, output logic ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (pcw_cnt > base) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus_req_o, bus_op_o, bus_addr_o, bus_wdata_o} !== 27'd0) begin
      bad++; $display("FAIL reset_bus got=%h exp=0", {bus_req_o, bus_op_o, bus_addr_o, bus_wdata_o});
    end
    total++;
    if ({stall_o, pc_wr_o, pc_wdata_o, sp_wr_o, sp_wdata_o} !== 35'd0) begin
      bad++; $display("FAIL reset_load got=%h exp=0", {stall_o, pc_wr_o, pc_wdata_o, sp_wr_o, sp_wdata_o});
    end
    total++;
    if ({iff1_o, iff2_o, im_o, halt_o} !== 5'd0) begin
      bad++; $display("FAIL reset_arch got=%b exp=00000", {iff1_o, iff2_o, im_o, halt_o});
    end
  endtask

  task automatic test_im1();
    logic st, ok; int base;
    pc_i = 16'h1234; sp_i = 16'h8000; i_reg_i = 8'h00; inta_byte = 8'hFF;
    bnd(1, 0, 0, 0, 1, 2'd1, st);
    log_n = 0; base = pcw_cnt;
    int_n_i = 0;
    repeat (3) @(posedge clk);
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL im1_stall got=%b exp=1", st); end
    wait_load(base, ok);
    int_n_i = 1;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL im1_timeout got=%b exp=1", ok); end
    total++; if (log_n !== 3) begin bad++; $display("FAIL im1_nbus got=%0d exp=3", log_n); end
    total++; if (log_op[0] !== 2'd0) begin bad++; $display("FAIL im1_inta got=%0d exp=0", log_op[0]); end
    total++;
    if ({log_op[1], log_addr[1], log_data[1]} !== {2'd1, 16'h7FFF, 8'h12}) begin
      bad++; $display("FAIL im1_push_h got=%0d/%h/%h exp=1/7fff/12", log_op[1], log_addr[1], log_data[1]);
    end
    total++;
    if ({log_op[2], log_addr[2], log_data[2]} !== {2'd1, 16'h7FFE, 8'h34}) begin
      bad++; $display("FAIL im1_push_l got=%0d/%h/%h exp=1/7ffe/34", log_op[2], log_addr[2], log_data[2]);
    end
    total++; if (pcw_val !== 16'h0038) begin bad++; $display("FAIL im1_pc got=%h exp=0038", pcw_val); end
    total++;
    if ({spw_seen, spw_val} !== {1'b1, 16'h7FFE}) begin
      bad++; $display("FAIL im1_sp got=%b/%h exp=1/7ffe", spw_seen, spw_val);
    end
    @(negedge clk);
    total++;
    if ({iff1_o, iff2_o, stall_o, bus_req_o} !== 4'b0000) begin
      bad++; $display("FAIL im1_after got=%b exp=0000", {iff1_o, iff2_o, stall_o, bus_req_o});
    end
  endtask

  task automatic test_im2();
    logic st, ok; int base;
    pc_i = 16'h5678; sp_i = 16'h9000; i_reg_i = 8'h80; inta_byte = 8'hFE;
    mem[16'h80FE] = 8'h00; mem[16'h80FF] = 8'h40;
    ack_wait = 2;
    bnd(1, 0, 0, 0, 1, 2'd2, st);
    log_n = 0; base = pcw_cnt;
    int_n_i = 0;
    repeat (3) @(posedge clk);
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    wait_load(base, ok);
    int_n_i = 1; ack_wait = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL im2_timeout got=%b exp=1", ok); end
    total++; if (log_n !== 5) begin bad++; $display("FAIL im2_nbus got=%0d exp=5", log_n); end
    total++;
    if ({log_op[2], log_addr[2], log_data[2]} !== {2'd1, 16'h8FFE, 8'h78}) begin
      bad++; $display("FAIL im2_push_l got=%0d/%h/%h exp=1/8ffe/78", log_op[2], log_addr[2], log_data[2]);
    end
    total++;
    if ({log_op[3], log_addr[3], log_op[4], log_addr[4]} !== {2'd2, 16'h80FE, 2'd2, 16'h80FF}) begin
      bad++; $display("FAIL im2_vec got=%0d/%h %0d/%h exp=2/80fe 2/80ff", log_op[3], log_addr[3], log_op[4], log_addr[4]);
    end
    total++; if (pcw_val !== 16'h4000) begin bad++; $display("FAIL im2_pc got=%h exp=4000", pcw_val); end
    total++; if (spw_val !== 16'h8FFE) begin bad++; $display("FAIL im2_sp got=%h exp=8ffe", spw_val); end
  endtask

  task automatic test_ei_shadow();
    logic st, ok; int base;
    pc_i = 16'h0200; sp_i = 16'hA000;
    bnd(1, 0, 0, 0, 1, 2'd1, st);
    int_n_i = 0;
    repeat (3) @(posedge clk);
    log_n = 0; base = pcw_cnt;
    bnd(1, 0, 0, 0, 0, 2'd0, st);
    total++; if (st !== 1'b0) begin bad++; $display("FAIL ei_shadow_blocked got=%b exp=0", st); end
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    total++; if (st !== 1'b1) begin bad++; $display("FAIL ei_shadow_nop got=%b exp=1", st); end
    wait_load(base, ok);
    int_n_i = 1;
    total++;
    if ({ok, pcw_val, log_op[0]} !== {1'b1, 16'h0038, 2'd0}) begin
      bad++; $display("FAIL ei_shadow_load got=%b/%h/%0d exp=1/0038/0", ok, pcw_val, log_op[0]);
    end
  endtask

  task automatic test_nmi_retn();
    logic st, ok; int base;
    pc_i = 16'h2000; sp_i = 16'h7000;
    bnd(1, 0, 0, 0, 0, 2'd0, st);
    log_n = 0; base = pcw_cnt;
    nmi_n_i = 0;
    repeat (4) @(posedge clk);
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    wait_load(base, ok);
    nmi_n_i = 1;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL nmi_timeout got=%b exp=1", ok); end
    total++;
    if ({log_n, log_op[0], log_addr[0]} !== {32'd2, 2'd1, 16'h6FFF}) begin
      bad++; $display("FAIL nmi_bus got=%0d/%0d/%h exp=2/1/6fff", log_n, log_op[0], log_addr[0]);
    end
    total++; if (pcw_val !== 16'h0066) begin bad++; $display("FAIL nmi_pc got=%h exp=0066", pcw_val); end
    total++;
    if ({iff1_o, iff2_o} !== 2'b01) begin bad++; $display("FAIL nmi_iff got=%b exp=01", {iff1_o, iff2_o}); end
    repeat (4) @(posedge clk);
    bnd(0, 0, 1, 0, 0, 2'd0, st);
    @(negedge clk);
    total++; if (iff1_o !== 1'b1) begin bad++; $display("FAIL retn_iff1 got=%b exp=1", iff1_o); end
    // NMI arriving mid INT sequence
    int_n_i = 0;
    repeat (3) @(posedge clk);
    ack_wait = 3; base = pcw_cnt; log_n = 0;
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    int_n_i = 1; nmi_n_i = 0;
    wait_load(base, ok);
    ack_wait = 0; nmi_n_i = 1;
    total++;
    if ({ok, pcw_val, log_op[0]} !== {1'b1, 16'h0038, 2'd0}) begin
      bad++; $display("FAIL nmi_mid_int got=%b/%h/%0d exp=1/0038/0", ok, pcw_val, log_op[0]);
    end
    @(negedge clk);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nmi_wait_bnd got=%b exp=0", stall_o); end
    base = pcw_cnt;
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    wait_load(base, ok);
    total++;
    if ({st, ok, pcw_val} !== {1'b1, 1'b1, 16'h0066}) begin
      bad++; $display("FAIL nmi_after_load got=%b/%b/%h exp=1/1/0066", st, ok, pcw_val);
    end
  endtask

  task automatic test_halt_wrap();
    logic st, ok; int base;
    pc_i = 16'h0101; sp_i = 16'h0000; inta_byte = 8'hD7;
    bnd(1, 0, 0, 0, 1, 2'd0, st);
    bnd(0, 0, 0, 1, 0, 2'd0, st);
    @(negedge clk);
    total++; if (halt_o !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halt_o); end
    log_n = 0; base = pcw_cnt;
    int_n_i = 0;
    wait_load(base, ok);
    int_n_i = 1;
    total++;
    if ({ok, halt_o} !== 2'b10) begin bad++; $display("FAIL halt_wake got=%b/%b exp=1/0", ok, halt_o); end
    total++;
    if ({log_addr[1], log_data[1], log_addr[2], log_data[2]} !== {16'hFFFF, 8'h01, 16'hFFFE, 8'h01}) begin
      bad++; $display("FAIL halt_wrap_push got=%h/%h %h/%h exp=ffff/01 fffe/01", log_addr[1], log_data[1], log_addr[2], log_data[2]);
    end
    total++;
    if ({pcw_val, spw_val} !== {16'h0010, 16'hFFFE}) begin
      bad++; $display("FAIL halt_rst10 got=%h/%h exp=0010/fffe", pcw_val, spw_val);
    end
    inta_byte = 8'h3E;
    bnd(1, 0, 0, 0, 0, 2'd0, st);
    int_n_i = 0;
    repeat (3) @(posedge clk);
    base = pcw_cnt;
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    wait_load(base, ok);
    int_n_i = 1;
    total++;
    if ({ok, pcw_val} !== {1'b1, 16'h0038}) begin
      bad++; $display("FAIL im0_non_rst got=%b/%h exp=1/0038", ok, pcw_val);
    end
  endtask

  task automatic test_reset_mid();
    logic st, found; int base;
    pc_i = 16'h3456; sp_i = 16'h4000;
    bnd(1, 0, 0, 0, 1, 2'd1, st);
    ack_budget = 2; log_n = 0; base = pcw_cnt;
    int_n_i = 0;
    repeat (3) @(posedge clk);
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    int_n_i = 1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_req_o && bus_addr_o == 16'h3FFE) begin found = 1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rmid_push_l got=%b exp=1", found); end
    nmi_n_i = 0;
    repeat (5) @(posedge clk);
`ifdef Z85_INTC_LATCNT_EN
    total++; if (irq_lat_o !== 16'd2) begin bad++; $display("FAIL rmid_lat got=%0d exp=2", irq_lat_o); end
`endif
    @(posedge clk); #1;
    rst_n = 0; nmi_n_i = 1;
    #1;
    total++;
    if ({bus_req_o, stall_o, pc_wr_o, sp_wr_o, bus_addr_o, iff1_o, iff2_o, im_o, halt_o} !== 25'd0) begin
      bad++; $display("FAIL rmid_outputs got=%h exp=0", {bus_req_o, stall_o, pc_wr_o, sp_wr_o, bus_addr_o, iff1_o, iff2_o, im_o, halt_o});
    end
`ifdef Z85_INTC_LATCNT_EN
    total++; if (irq_lat_o !== 16'd0) begin bad++; $display("FAIL rmid_lat_rst got=%0d exp=0", irq_lat_o); end
`endif
    repeat (2) @(posedge clk);
    #1; rst_n = 1; ack_budget = 1000;
    total++; if (pcw_cnt !== base) begin bad++; $display("FAIL rmid_no_pcwr got=%0d exp=%0d", pcw_cnt, base); end
    bnd(0, 0, 0, 0, 0, 2'd0, st);
    total++; if (st !== 1'b0) begin bad++; $display("FAIL rmid_nmi_clear got=%b exp=0", st); end
  endtask

  initial begin
    clr_inputs();
    rst_n = 0; nmi_n_i = 1; int_n_i = 1;
    pc_i = '0; sp_i = '0; i_reg_i = '0;
    bus_ack_i = 0; bus_rdata_i = '0;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_im1();
    test_im2();
    test_ei_shadow();
    test_nmi_retn();
    test_halt_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
